// File: rtl/resistor_pullup_pkg.sv
// Shared types and constants for the resistive pull-up line model.
// Optional feature macro: RESISTOR_PULLUP_GLITCH_COUNT_EN (adds GLITCH_COUNT on the top).
package resistor_pullup_pkg;

    // Per-channel line state; LOW must encode as zero so reset is all-zeros.
    typedef enum logic [1:0] {
        StLow    = 2'd0,
        StRising = 2'd1,
        StHigh   = 2'd2
    } line_state_e;

    localparam int unsigned GLITCH_W = 16;

    // Counter width able to hold 0..rise_cycles.
    function automatic int unsigned cnt_width(input int unsigned rise_cycles);
        return $clog2(rise_cycles + 1);
    endfunction

endpackage

// File: rtl/resistor_pullup_cell.sv
// One open-drain channel: immediate fall, RC-style delayed rise, registered edge strobes.
// abort flags a rise that is cut short on this edge (RISING -> LOW).
module resistor_pullup_cell
    import resistor_pullup_pkg::*;
#(
    parameter int unsigned RISE_CYCLES = 4,
    parameter int unsigned CNT_W       = cnt_width(RISE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic released,
    output logic o,
    output logic rose,
    output logic fell,
    output logic abort
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RISE_CYCLES - 1);

    line_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rose_q, rose_d;
    logic             fell_q, fell_d;

    // Next-state, rise counter, edge strobes and abort detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        unique case (state_q)
            StLow: begin
                if (released) begin
                    if (RISE_CYCLES == 1) begin
                        state_d = StHigh;
                    end else begin
                        state_d = StRising;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StRising: begin
                if (!released) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (!released) begin
                    state_d = StLow;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
            end
        endcase
        rose_d = (state_d == StHigh) && (state_q != StHigh);
        fell_d = (state_q == StHigh) && (state_d != StHigh);
    end

    // State register; reset drops the line without a fall strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StLow;
            cnt_q   <= '0;
            rose_q  <= 1'b0;
            fell_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rose_q  <= rose_d;
            fell_q  <= fell_d;
        end
    end

    assign o    = (state_q == StHigh);
    assign rose = rose_q;
    assign fell = fell_q;

endmodule

// File: rtl/resistor_pullup_rc.sv
// Multi-channel open-drain lines with resistive pull-ups and RC rise delay.
// Optional feature macro: RESISTOR_PULLUP_GLITCH_COUNT_EN adds a saturating
// GLITCH_COUNT of aborted rises summed over all channels.
module resistor_pullup_rc
    import resistor_pullup_pkg::*;
#(
    parameter int unsigned CHANNELS    = 8,
    parameter int unsigned RISE_CYCLES = 4,
    parameter int unsigned CNT_W       = cnt_width(RISE_CYCLES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                VCC,
    input  logic [CHANNELS-1:0] DRIVE_LOW,
`ifdef RESISTOR_PULLUP_GLITCH_COUNT_EN
    output logic [GLITCH_W-1:0] GLITCH_COUNT,
`endif
    output logic [CHANNELS-1:0] O,
    output logic [CHANNELS-1:0] ROSE,
    output logic [CHANNELS-1:0] FELL
);

    logic [CHANNELS-1:0] released;
    logic [CHANNELS-1:0] abort;

    // A missing supply holds every line low regardless of drivers.
    assign released = ~DRIVE_LOW & {CHANNELS{VCC}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
        resistor_pullup_cell #(
            .RISE_CYCLES (RISE_CYCLES),
            .CNT_W       (CNT_W)
        ) u_cell (
            .clk      (CLK),
            .rst      (RESET),
            .released (released[i]),
            .o        (O[i]),
            .rose     (ROSE[i]),
            .fell     (FELL[i]),
            .abort    (abort[i])
        );
    end

`ifdef RESISTOR_PULLUP_GLITCH_COUNT_EN
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic [31:0]         abort_sum;
    logic [31:0]         glitch_sum;

    // Add this cycle's abort popcount, saturating at all-ones.
    always_comb begin
        abort_sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            abort_sum = abort_sum + 32'(abort[i]);
        end
        glitch_sum = 32'(glitch_q) + abort_sum;
        glitch_d   = (glitch_sum > 32'(16'hFFFF)) ? '1 : glitch_sum[GLITCH_W-1:0];
    end

    // Glitch accumulator register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign GLITCH_COUNT = glitch_q;
`else
    logic unused_abort;
    assign unused_abort = ^abort;
`endif

endmodule
